// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - fetch-stage bus: hazard/redirect inputs, instr_mem port, IF/ID outputs.
interface instr_fetch_if;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] instruction;
  logic [31:0] addr_from_pc;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        halted;
  logic        misalign_err;

  modport master (
    input  stall, branch_taken, branch_target, instruction,
    output addr_from_pc, if_id_pc, if_id_instr, if_id_valid, halted, misalign_err
  );

  modport slave (
    output stall, branch_taken, branch_target, instruction,
    input  addr_from_pc, if_id_pc, if_id_instr, if_id_valid, halted, misalign_err
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - RISC-V fetch stage: PC, IF/ID register, stall, redirect, EBREAK halt, misalign trap.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR = 32'h0010_0073,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_if.master bus
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        halted;
  logic        misalign_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= BOOT;
      pc           <= RESET_PC;
      if_id_pc     <= 32'h0000_0000;
      if_id_instr  <= NOP_INSTR;
      if_id_valid  <= 1'b0;
      halted       <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state <= RUN;
        end
        RUN: begin
          if (bus.branch_taken) begin
            // A redirect kills the wrong-path instruction even under stall.
            if_id_valid <= 1'b0;
            if (bus.branch_target[1:0] == 2'b00) begin
              pc          <= bus.branch_target;
              if_id_instr <= NOP_INSTR;
            end else begin
              misalign_err <= 1'b1;
              halted       <= 1'b1;
              state        <= HALTED;
            end
          end else if (!bus.stall) begin
            if_id_pc    <= pc;
            if_id_instr <= bus.instruction;
            if_id_valid <= 1'b1;
            if (bus.instruction == HALT_INSTR) begin
              halted <= 1'b1;
              state  <= HALTED;
            end else begin
              pc <= pc + 32'd4;
            end
          end
        end
        HALTED: begin
          // A stalled EBREAK stays visible in IF/ID until decode accepts it.
          if (!bus.stall) begin
            if_id_valid <= 1'b0;
          end
        end
        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

  assign bus.addr_from_pc = pc;
  assign bus.if_id_pc     = if_id_pc;
  assign bus.if_id_instr  = if_id_instr;
  assign bus.if_id_valid  = if_id_valid;
  assign bus.halted       = halted;
  assign bus.misalign_err = misalign_err;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed plus randomized bench for instr_fetch_unit against a behavioural model.
module tb_instr_fetch_unit;
  localparam logic [31:0] HALT = 32'h0010_0073;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] mem [0:63];

  instr_fetch_if bus ();

  instr_fetch_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Low 256 bytes come from mem; elsewhere a fixed address scramble that never equals EBREAK.
  function automatic logic [31:0] imem(input logic [31:0] a);
    if (a < 32'h100) return mem[a[7:2]];
    return a ^ 32'hA5A5_0000;
  endfunction

  always_comb bus.instruction = imem(bus.addr_from_pc);

  // Behavioural model: what the fetch stage must show after each edge.
  bit          m_boot, m_halt, m_valid, m_mis;
  logic [31:0] m_pc, m_ipc, m_instr, fetched;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_boot = 1; m_halt = 0; m_valid = 0; m_mis = 0;
      m_pc = 32'h0; m_ipc = 32'h0; m_instr = NOP;
    end else if (m_boot) begin
      m_boot = 0;
    end else if (m_halt) begin
      if (!bus.stall) m_valid = 0;
    end else if (bus.branch_taken) begin
      m_valid = 0;
      if (bus.branch_target % 4 == 0) begin
        m_pc = bus.branch_target;
        m_instr = NOP;
      end else begin
        m_mis = 1;
        m_halt = 1;
      end
    end else if (!bus.stall) begin
      fetched = imem(m_pc);
      m_ipc = m_pc;
      m_instr = fetched;
      m_valid = 1;
      if (fetched == HALT) m_halt = 1;
      else m_pc = m_pc + 4;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("m_pc",    bus.addr_from_pc, m_pc);
    chk("m_ipc",   bus.if_id_pc,     m_ipc);
    chk("m_instr", bus.if_id_instr,  m_instr);
    chk("m_valid", {31'b0, bus.if_id_valid},  {31'b0, m_valid});
    chk("m_halt",  {31'b0, bus.halted},       {31'b0, m_halt});
    chk("m_mis",   {31'b0, bus.misalign_err}, {31'b0, m_mis});
  end

  task automatic cyc(input logic s, input logic b, input logic [31:0] t);
    bus.stall = s;
    bus.branch_taken = b;
    bus.branch_target = t;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Ends just after the BOOT edge; reset values are pinned while rst_n is low.
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    bus.stall = 0; bus.branch_taken = 0; bus.branch_target = 0;
    #1;
    chk("rst_pc",    bus.addr_from_pc, 32'h0);
    chk("rst_ipc",   bus.if_id_pc,     32'h0);
    chk("rst_instr", bus.if_id_instr,  NOP);
    chk("rst_flags", {29'b0, bus.if_id_valid, bus.halted, bus.misalign_err}, 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i * 4;
    mem[0] = 32'hDEAC_AEEF;
    mem[1] = 32'h1234_5678;
    mem[2] = 32'hAABB_CCDD;
    mem[3] = HALT;
    mem[16] = 32'h0BAD_F00D;
    bus.stall = 0; bus.branch_taken = 0; bus.branch_target = 0;

    // Free-run, stall, resume, EBREAK halt.
    do_reset();
    chk("boot_pc", bus.addr_from_pc, 32'h0);
    chk("boot_valid", {31'b0, bus.if_id_valid}, 32'h0);
    cyc(0, 0, 0);
    chk("t1_pc", bus.addr_from_pc, 32'h4);
    chk("t1_ipc", bus.if_id_pc, 32'h0);
    chk("t1_instr", bus.if_id_instr, 32'hDEAC_AEEF);
    cyc(0, 0, 0);
    chk("t1_pc2", bus.addr_from_pc, 32'h8);
    chk("t1_instr2", bus.if_id_instr, 32'h1234_5678);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    chk("t2_pc", bus.addr_from_pc, 32'h8);
    chk("t2_ipc", bus.if_id_pc, 32'h4);
    chk("t2_valid", {31'b0, bus.if_id_valid}, 32'h1);
    cyc(0, 0, 0);
    chk("t2_ipc2", bus.if_id_pc, 32'h8);
    chk("t2_instr2", bus.if_id_instr, 32'hAABB_CCDD);
    cyc(0, 0, 0);
    chk("t4_ipc", bus.if_id_pc, 32'hC);
    chk("t4_instr", bus.if_id_instr, HALT);
    chk("t4_halt", {30'b0, bus.halted, bus.if_id_valid}, 32'h3);
    chk("t4_pc", bus.addr_from_pc, 32'hC);
    cyc(1, 0, 0);
    chk("t4_stall_valid", {31'b0, bus.if_id_valid}, 32'h1);
    cyc(0, 0, 0);
    chk("t4_valid0", {31'b0, bus.if_id_valid}, 32'h0);

    // Redirect under stall, then misaligned trap.
    do_reset();
    cyc(0, 0, 0);
    cyc(1, 1, 32'h40);
    chk("t3_pc", bus.addr_from_pc, 32'h40);
    chk("t3_valid", {31'b0, bus.if_id_valid}, 32'h0);
    chk("t3_instr", bus.if_id_instr, NOP);
    cyc(0, 0, 0);
    chk("t3_ipc", bus.if_id_pc, 32'h40);
    chk("t3_instr2", bus.if_id_instr, 32'h0BAD_F00D);
    cyc(0, 1, 32'h42);
    chk("t5_flags", {30'b0, bus.misalign_err, bus.halted}, 32'h3);
    chk("t5_pc", bus.addr_from_pc, 32'h44);
    cyc(0, 1, 32'h80);
    chk("t5_pc2", bus.addr_from_pc, 32'h44);

    // Wrap past the top of the address space, then async reset mid-cycle.
    do_reset();
    cyc(0, 1, 32'hFFFF_FFFC);
    chk("t6_pc", bus.addr_from_pc, 32'hFFFF_FFFC);
    cyc(0, 0, 0);
    chk("t6_wrap", bus.addr_from_pc, 32'h0);
    chk("t6_instr", bus.if_id_instr, 32'h5A5A_FFFC);
    cyc(0, 0, 0);
    chk("t6_pc4", bus.addr_from_pc, 32'h4);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_pc", bus.addr_from_pc, 32'h0);
    chk("t6_async_valid", {31'b0, bus.if_id_valid}, 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Randomized phase over a fresh program image.
    for (int i = 0; i < 64; i++) mem[i] = ($urandom_range(0, 15) == 0) ? HALT : $urandom;
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      if (m_halt || $urandom_range(0, 60) == 0) begin
        do_reset();
      end else begin
        logic [31:0] t;
        if ($urandom_range(0, 19) == 0) t = ($urandom & 32'hFC) | $urandom_range(1, 3);
        else if ($urandom_range(0, 9) == 0) t = $urandom & 32'hFFFF_FFFC;
        else t = $urandom & 32'hFC;
        cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0), t);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
